// File: rtl/dma_xfer_ctrl_pkg.sv
// Shared types and defaults for the single-channel DMA sequencer.
package dma_xfer_ctrl_pkg;

  localparam int DEF_AW     = 16;
  localparam int DEF_LW     = 16;
  localparam int DEF_BURST  = 8;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD,
    ST_WR,
    ST_FIN
  } state_e;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dma_xfer_ctrl_if.sv
// Control, memory-bus and FIFO-side signals of the DMA sequencer.
interface dma_xfer_ctrl_if
  import dma_xfer_ctrl_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int LW = DEF_LW
) ();

  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] xfer_len;
  logic          busy;
  logic          done;
  logic          bus_req;
  logic          bus_gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_rdy;
  logic          fifo_wr_en;
  logic          fifo_rd_en;
  logic          fifo_empty;
  logic          fifo_full;

  modport master (
    input  start, src_addr, dst_addr, xfer_len, bus_gnt, mem_rdy, fifo_empty, fifo_full,
    output busy, done, bus_req, mem_addr, mem_rd, mem_wr, fifo_wr_en, fifo_rd_en
  );

  modport slave (
    output start, src_addr, dst_addr, xfer_len, bus_gnt, mem_rdy, fifo_empty, fifo_full,
    input  busy, done, bus_req, mem_addr, mem_rd, mem_wr, fifo_wr_en, fifo_rd_en
  );

endinterface

// File: rtl/dma_xfer_ctrl_ptr_cnt.sv
// Address pointer plus words-remaining counter; one instance per transfer side.
module dma_xfer_ctrl_ptr_cnt
  import dma_xfer_ctrl_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int LW = DEF_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic [AW-1:0] addr_i,
  input  logic [LW-1:0] len_i,
  output logic [AW-1:0] ptr_o,
  output logic [LW-1:0] left_o,
  output logic          zero_o
);

  logic [AW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] left_q, left_d;

  // Pointer wraps silently; the remaining count saturates at zero.
  always_comb begin
    ptr_d  = ptr_q;
    left_d = left_q;
    if (load_i) begin
      ptr_d  = addr_i;
      left_d = len_i;
    end else if (inc_i && (left_q != '0)) begin
      ptr_d  = ptr_q + AW'(1);
      left_d = left_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      left_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      left_q <= left_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign left_o = left_q;
  assign zero_o = (left_q == '0);

endmodule

// File: rtl/dma_xfer_ctrl.sv
// DMA sequencer: read bursts from source into the FIFO, drain to destination, repeat.
// Strobes decode the registered state, gated by grant and FIFO flags so a grant drop bites the same cycle.
module dma_xfer_ctrl
  import dma_xfer_ctrl_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int LW    = DEF_LW,
  parameter int BURST = DEF_BURST
) (
  input logic             clk,
  input logic             rst,
  dma_xfer_ctrl_if.master bus_if
);

  localparam int BW = cnt_w(BURST);

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          req_q, req_d;
  logic          load;
  logic          rd_ok, wr_ok, rd_beat, wr_beat;
  logic [AW-1:0] src_ptr, dst_ptr;
  logic [LW-1:0] src_left, dst_left;
  logic          src_zero, dst_zero;

  dma_xfer_ctrl_ptr_cnt #(.AW(AW), .LW(LW)) u_src (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .inc_i  (rd_beat),
    .addr_i (bus_if.src_addr),
    .len_i  (bus_if.xfer_len),
    .ptr_o  (src_ptr),
    .left_o (src_left),
    .zero_o (src_zero)
  );

  dma_xfer_ctrl_ptr_cnt #(.AW(AW), .LW(LW)) u_dst (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .inc_i  (wr_beat),
    .addr_i (bus_if.dst_addr),
    .len_i  (bus_if.xfer_len),
    .ptr_o  (dst_ptr),
    .left_o (dst_left),
    .zero_o (dst_zero)
  );

  assign rd_ok   = (state_q == ST_RD) && bus_if.bus_gnt && !src_zero &&
                   (beat_q < BW'(BURST)) && !bus_if.fifo_full;
  assign wr_ok   = (state_q == ST_WR) && bus_if.bus_gnt && !bus_if.fifo_empty;
  assign rd_beat = rd_ok && bus_if.mem_rdy;
  assign wr_beat = wr_ok && bus_if.mem_rdy;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.start) begin
          load    = 1'b1;
          state_d = (bus_if.xfer_len == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_if.bus_gnt) state_d = ST_RD;
      end
      ST_RD: begin
        if (bus_if.bus_gnt) begin
          if (rd_beat) beat_d = beat_q + BW'(1);
          // Leave on the beat that exhausts the burst/length, or at once if no beat is possible.
          if (!rd_ok || (rd_beat && ((src_left == LW'(1)) || (beat_q == BW'(BURST - 1))))) begin
            state_d = ST_WR;
            beat_d  = '0;
          end
        end
      end
      ST_WR: begin
        if (bus_if.bus_gnt) begin
          if (wr_beat && (dst_left == LW'(1))) state_d = ST_FIN;
          else if (bus_if.fifo_empty)          state_d = dst_zero ? ST_FIN : ST_RD;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    req_d  = (state_d == ST_REQ) || (state_d == ST_RD) || (state_d == ST_WR);
    done_d = (state_q == ST_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
    end
  end

  assign bus_if.busy       = busy_q;
  assign bus_if.done       = done_q;
  assign bus_if.bus_req    = req_q;
  assign bus_if.mem_rd     = rd_ok;
  assign bus_if.mem_wr     = wr_ok;
  assign bus_if.fifo_wr_en = rd_beat;
  assign bus_if.fifo_rd_en = wr_beat;
  assign bus_if.mem_addr   = (state_q == ST_RD) ? src_ptr :
                             (state_q == ST_WR) ? dst_ptr : '0;

endmodule
